// File: rtl/zeus_clk_pkg.sv
// Shared types and constants for the phi2 bus clock generator.
// Contents:
//   phi2_state_t        - phase state of the generator (LOW, HIGH, STRETCH)
//   PHI2_TAP_FIELD_W    - width of one tap_cycle field and of the phase counters
//   PHI2_DEF_LOW_COUNT  - low-phase count loaded at reset (phase = count+1 clks)
//   PHI2_DEF_HIGH_COUNT - high-phase count loaded at reset
package zeus_clk_pkg;

  typedef enum logic [1:0] {
    LOW     = 2'd0,
    HIGH    = 2'd1,
    STRETCH = 2'd2
  } phi2_state_t;

  localparam int PHI2_TAP_FIELD_W = 12;

  localparam logic [PHI2_TAP_FIELD_W-1:0] PHI2_DEF_LOW_COUNT  = 12'd11;
  localparam logic [PHI2_TAP_FIELD_W-1:0] PHI2_DEF_HIGH_COUNT = 12'd11;

endpackage

// File: rtl/phi2_tap_decoder.sv
// Tap comparators for the phi2 generator. Purely combinational: it looks at the
// state and phase counter the generator is about to enter, so the registered
// tap_strobe in the top lines up with that cycle.
// Ports:
//   state_nxt  in   next generator state
//   cycle_nxt  in   next phi2_cycle value
//   tap_cycle  in   NUM_TAPS packed high-phase cycle indices
//   tap_hit    out  per-tap match for the next cycle
module phi2_tap_decoder
  import zeus_clk_pkg::*;
#(
  parameter int CNT_WIDTH = PHI2_TAP_FIELD_W,
  parameter int NUM_TAPS  = 4
) (
  input  phi2_state_t                   state_nxt,
  input  logic [CNT_WIDTH-1:0]          cycle_nxt,
  input  logic [NUM_TAPS*CNT_WIDTH-1:0] tap_cycle,
  output logic [NUM_TAPS-1:0]           tap_hit
);

  // Only the HIGH state fires taps; in STRETCH the counter sits at high_active,
  // so a tap on the last high cycle must not repeat while the phase is held.
  always_comb begin
    tap_hit = '0;
    for (int i = 0; i < NUM_TAPS; i++) begin
      tap_hit[i] = (state_nxt == HIGH) &&
                   (cycle_nxt == tap_cycle[i*CNT_WIDTH +: CNT_WIDTH]);
    end
  end

endmodule

// File: rtl/phi2_timing_generator.sv
// phi2 bus clock generator with programmable low/high phase lengths.
// clk_phi2 is low for low_active+1 clks and high for high_active+1 clks.
// New counts are taken through a one-entry pending slot and only become active
// on a falling phase boundary, so a phase never changes length once started.
// Optional build macro PHI2_STRETCH_EN adds high-phase stretching: while
// stretch_req is held at the end of the high phase the phase is extended, up to
// STRETCH_MAX extra clks, after which it is released with stretch_timeout.
//
// Handshake: a config word is transferred on any rising clk edge where
// cfg_valid && cfg_ready; cfg_ready then stays low until the word has been
// applied at the next phase fall.
//
// Ports:
//   clk, reset          system clock, asynchronous active-high reset
//   cfg_low_count       requested low-phase count
//   cfg_high_count      requested high-phase count
//   cfg_valid/cfg_ready config handshake
//   tap_cycle           per-tap high-phase cycle index, tap i at [i*CNT_WIDTH +: CNT_WIDTH]
//   stretch_req         peripheral asks for a longer high phase
//   clk_phi2            bus clock
//   phi2_cycle          clk index inside the current phase
//   phi2_rise/phi2_fall strobe in the first clk of the high / low phase
//   tap_strobe          one-clk tap strobes inside the high phase
//   stretching          high phase currently extended
//   stretch_timeout     strobe on a forced release
//   state_dbg           current generator state
module phi2_timing_generator
  import zeus_clk_pkg::*;
#(
  parameter int                   CNT_WIDTH      = PHI2_TAP_FIELD_W,
  parameter logic [CNT_WIDTH-1:0] DEF_LOW_COUNT  = CNT_WIDTH'(PHI2_DEF_LOW_COUNT),
  parameter logic [CNT_WIDTH-1:0] DEF_HIGH_COUNT = CNT_WIDTH'(PHI2_DEF_HIGH_COUNT),
  parameter int                   NUM_TAPS       = 4,
  parameter int                   STRETCH_MAX    = 255
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [CNT_WIDTH-1:0]          cfg_low_count,
  input  logic [CNT_WIDTH-1:0]          cfg_high_count,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [NUM_TAPS*CNT_WIDTH-1:0] tap_cycle,
  input  logic                          stretch_req,
  output logic                          clk_phi2,
  output logic [CNT_WIDTH-1:0]          phi2_cycle,
  output logic                          phi2_rise,
  output logic                          phi2_fall,
  output logic [NUM_TAPS-1:0]           tap_strobe,
  output logic                          stretching,
  output logic                          stretch_timeout,
  output phi2_state_t                   state_dbg
);

  phi2_state_t          state, state_nxt;
  logic [CNT_WIDTH-1:0] cycle_nxt;
  logic [CNT_WIDTH-1:0] low_active, high_active;
  logic [CNT_WIDTH-1:0] pend_low, pend_high;
  logic                 rise_nxt, fall_nxt;
  logic                 stretch_go;
  logic [NUM_TAPS-1:0]  tap_hit;

`ifdef PHI2_STRETCH_EN
  localparam int SCNT_W = $clog2(STRETCH_MAX + 1);
  // Number of stretch clks spent so far, including the current one.
  logic [SCNT_W-1:0] scnt, scnt_nxt;
  logic              timeout_nxt;
  assign stretch_go = stretch_req;
`else
  localparam int STRETCH_MAX_UNUSED = STRETCH_MAX;
  logic stretch_req_unused;
  assign stretch_req_unused = stretch_req;
  assign stretch_go         = 1'b0;
  assign stretching         = 1'b0;
  assign stretch_timeout    = 1'b0;
`endif

  assign state_dbg = state;

  always_comb begin
    state_nxt = state;
    cycle_nxt = phi2_cycle + CNT_WIDTH'(1);
    rise_nxt  = 1'b0;
    fall_nxt  = 1'b0;
`ifdef PHI2_STRETCH_EN
    scnt_nxt    = scnt;
    timeout_nxt = 1'b0;
`endif
    case (state)
      LOW: begin
        if (phi2_cycle == low_active) begin
          state_nxt = HIGH;
          cycle_nxt = '0;
          rise_nxt  = 1'b1;
        end
      end
      HIGH: begin
        if (phi2_cycle == high_active) begin
          if (stretch_go) begin
            state_nxt = STRETCH;
            cycle_nxt = phi2_cycle;
`ifdef PHI2_STRETCH_EN
            scnt_nxt  = SCNT_W'(1);
`endif
          end else begin
            state_nxt = LOW;
            cycle_nxt = '0;
            fall_nxt  = 1'b1;
          end
        end
      end
      STRETCH: begin
        cycle_nxt = phi2_cycle;
`ifdef PHI2_STRETCH_EN
        if (!stretch_req) begin
          state_nxt = LOW;
          cycle_nxt = '0;
          fall_nxt  = 1'b1;
        end else if (scnt >= SCNT_W'(STRETCH_MAX)) begin
          state_nxt   = LOW;
          cycle_nxt   = '0;
          fall_nxt    = 1'b1;
          timeout_nxt = 1'b1;
        end else begin
          scnt_nxt = scnt + SCNT_W'(1);
        end
`else
        state_nxt = LOW;
        cycle_nxt = '0;
        fall_nxt  = 1'b1;
`endif
      end
      default: begin
        state_nxt = LOW;
        cycle_nxt = '0;
      end
    endcase
  end

  phi2_tap_decoder #(
    .CNT_WIDTH (CNT_WIDTH),
    .NUM_TAPS  (NUM_TAPS)
  ) u_tap_decoder (
    .state_nxt (state_nxt),
    .cycle_nxt (cycle_nxt),
    .tap_cycle (tap_cycle),
    .tap_hit   (tap_hit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= LOW;
      phi2_cycle  <= '0;
      clk_phi2    <= 1'b0;
      phi2_rise   <= 1'b0;
      phi2_fall   <= 1'b0;
      tap_strobe  <= '0;
      low_active  <= DEF_LOW_COUNT;
      high_active <= DEF_HIGH_COUNT;
      pend_low    <= '0;
      pend_high   <= '0;
      cfg_ready   <= 1'b1;
`ifdef PHI2_STRETCH_EN
      scnt            <= '0;
      stretching      <= 1'b0;
      stretch_timeout <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      phi2_cycle <= cycle_nxt;
      clk_phi2   <= (state_nxt != LOW);
      phi2_rise  <= rise_nxt;
      phi2_fall  <= fall_nxt;
      tap_strobe <= tap_hit;
`ifdef PHI2_STRETCH_EN
      scnt            <= scnt_nxt;
      stretching      <= (state_nxt == STRETCH);
      stretch_timeout <= timeout_nxt;
`endif
      // cfg_ready doubles as "pending slot empty", so accepting and applying
      // are mutually exclusive: a word accepted on a fall edge waits for the
      // following fall.
      if (cfg_valid && cfg_ready) begin
        pend_low  <= cfg_low_count;
        pend_high <= cfg_high_count;
        cfg_ready <= 1'b0;
      end else if (fall_nxt && !cfg_ready) begin
        low_active  <= pend_low;
        high_active <= pend_high;
        cfg_ready   <= 1'b1;
      end
    end
  end

endmodule
